// File: rtl/huffman_decoder.sv
// huffman_decoder: serial MSB-first Huffman decoder with a loadable 10-entry code table.
// Optional macro HUFF_DEC_STATS_EN adds the Bits_used accepted-bit counter output.
`default_nettype none

module huffman_decoder #(
    parameter int SYM_N   = 10,
    parameter int MAX_LEN = 9,
    parameter int CNT_W   = 16
) (
    input  logic               Clk_in,
    input  logic               Rst,
    input  logic               Tbl_we,
    input  logic [3:0]         Tbl_addr,
    input  logic [3:0]         Tbl_len,
    input  logic [MAX_LEN-1:0] Tbl_code,
    input  logic               Start_dec,
    input  logic [CNT_W-1:0]   Sym_count,
    input  logic               Bit_in,
    input  logic               Bit_valid,
    output logic               Bit_ready,
    output logic [3:0]         Sym_out,
    output logic               Sym_valid,
    input  logic               Sym_ready,
    output logic               Busy,
    output logic               Fin,
`ifdef HUFF_DEC_STATS_EN
    output logic [CNT_W+3:0]   Bits_used,
`endif
    output logic               Err
);

    localparam logic [3:0]       c_sym_n   = 4'(SYM_N);
    localparam logic [3:0]       c_max_len = 4'(MAX_LEN);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_MATCH = 2'd2,
        S_EMIT  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_tbl_len  [SYM_N];
    logic [MAX_LEN-1:0] r_tbl_code [SYM_N];
    logic [MAX_LEN-1:0] r_acc;
    logic [3:0]         r_len;
    logic [CNT_W-1:0]   r_remaining;
    logic [3:0]         r_sym_out;
    logic               r_err;
    logic               r_fin_zero;
    logic               w_fin_last;
    logic               w_hit;
    logic [3:0]         w_hit_idx;

    always_ff @(posedge Clk_in) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = 4'd0;
        for (int i = SYM_N - 1; i >= 0; i--) begin
            if (r_tbl_len[i] == r_len && r_tbl_code[i] == r_acc) begin
                w_hit     = 1'b1;
                w_hit_idx = 4'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        Bit_ready   = 1'b0;
        Sym_valid   = 1'b0;
        w_fin_last  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start_dec && Sym_count != '0) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                Bit_ready = 1'b1;
                if (Bit_valid) begin
                    w_state_nxt = S_MATCH;
                end
            end
            S_MATCH: begin
                if (w_hit) begin
                    w_state_nxt = S_EMIT;
                end else if (r_len == c_max_len) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_EMIT: begin
                Sym_valid = 1'b1;
                if (Sym_ready) begin
                    if (r_remaining == c_cnt_one) begin
                        w_fin_last  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_SHIFT;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign Busy    = (r_state != S_IDLE);
    assign Sym_out = r_sym_out;
    assign Err     = r_err;
    // Zero-count starts finish one cycle later; normal decodes finish on the last handoff.
    assign Fin     = r_fin_zero | w_fin_last;

    always_ff @(posedge Clk_in) begin
        if (Rst) begin
            for (int i = 0; i < SYM_N; i++) begin
                r_tbl_len[i]  <= 4'd0;
                r_tbl_code[i] <= '0;
            end
            r_acc       <= '0;
            r_len       <= 4'd0;
            r_remaining <= '0;
            r_sym_out   <= 4'd0;
            r_err       <= 1'b0;
            r_fin_zero  <= 1'b0;
        end else begin
            r_fin_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Tbl_we && Tbl_addr < c_sym_n) begin
                        r_tbl_len[Tbl_addr]  <= (Tbl_len > c_max_len) ? 4'd0 : Tbl_len;
                        r_tbl_code[Tbl_addr] <= Tbl_code;
                    end
                    if (Start_dec) begin
                        r_err <= 1'b0;
                        if (Sym_count == '0) begin
                            r_fin_zero <= 1'b1;
                        end else begin
                            r_remaining <= Sym_count;
                            r_acc       <= '0;
                            r_len       <= 4'd0;
                        end
                    end
                end
                S_SHIFT: begin
                    if (Bit_valid) begin
                        r_acc <= {r_acc[MAX_LEN-2:0], Bit_in};
                        r_len <= r_len + 4'd1;
                    end
                end
                S_MATCH: begin
                    if (w_hit) begin
                        r_sym_out <= w_hit_idx;
                    end else if (r_len == c_max_len) begin
                        r_err <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (Sym_ready) begin
                        r_remaining <= r_remaining - c_cnt_one;
                        r_acc       <= '0;
                        r_len       <= 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HUFF_DEC_STATS_EN
    localparam logic [CNT_W+3:0] c_bits_one = (CNT_W+4)'(1);
    logic [CNT_W+3:0] r_bits_used;

    always_ff @(posedge Clk_in) begin
        if (Rst) begin
            r_bits_used <= '0;
        end else if (r_state == S_IDLE && Start_dec) begin
            r_bits_used <= '0;
        end else if (r_state == S_SHIFT && Bit_valid) begin
            r_bits_used <= r_bits_used + c_bits_one;
        end
    end

    assign Bits_used = r_bits_used;
`endif

endmodule

`default_nettype wire

// File: tb/tb_huffman_decoder.sv
// tb_huffman_decoder: scoreboard-based self-checking bench for huffman_decoder.
`default_nettype none

module tb_huffman_decoder;

    localparam int SYM_N   = 10;
    localparam int MAX_LEN = 9;
    localparam int CNT_W   = 16;

    logic               Clk_in = 1'b0;
    logic               Rst = 1'b1;
    logic               Tbl_we = 1'b0;
    logic [3:0]         Tbl_addr = '0;
    logic [3:0]         Tbl_len = '0;
    logic [MAX_LEN-1:0] Tbl_code = '0;
    logic               Start_dec = 1'b0;
    logic [CNT_W-1:0]   Sym_count = '0;
    logic               Bit_in = 1'b0;
    logic               Bit_valid = 1'b0;
    logic               Bit_ready;
    logic [3:0]         Sym_out;
    logic               Sym_valid;
    logic               Sym_ready = 1'b0;
    logic               Busy;
    logic               Fin;
    logic               Err;
`ifdef HUFF_DEC_STATS_EN
    logic [CNT_W+3:0]   Bits_used;
`endif

    huffman_decoder #(.SYM_N(SYM_N), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .Clk_in    (Clk_in),
        .Rst       (Rst),
        .Tbl_we    (Tbl_we),
        .Tbl_addr  (Tbl_addr),
        .Tbl_len   (Tbl_len),
        .Tbl_code  (Tbl_code),
        .Start_dec (Start_dec),
        .Sym_count (Sym_count),
        .Bit_in    (Bit_in),
        .Bit_valid (Bit_valid),
        .Bit_ready (Bit_ready),
        .Sym_out   (Sym_out),
        .Sym_valid (Sym_valid),
        .Sym_ready (Sym_ready),
        .Busy      (Busy),
        .Fin       (Fin),
`ifdef HUFF_DEC_STATS_EN
        .Bits_used (Bits_used),
`endif
        .Err       (Err)
    );

    always #5 Clk_in = ~Clk_in;

    int n_tests = 0;
    int n_fail  = 0;
    int fin_cnt = 0;
    int exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Handoffs are judged just before the edge that completes them.
    always @(negedge Clk_in) begin
        if (Sym_valid && Sym_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sym", 32'(Sym_valid), 32'd0);
            end else begin
                check("sym_out", 32'(Sym_out), 32'(exp_q.pop_front()));
            end
        end
        if (Fin) begin
            fin_cnt++;
            check("fin_with_last_sym", 32'(exp_q.size()), 32'd0);
        end
    end

    task automatic tick();
        @(posedge Clk_in);
        #1;
    endtask

    task automatic tbl_write(input int addr, input int len, input int code);
        Tbl_we   = 1'b1;
        Tbl_addr = 4'(addr);
        Tbl_len  = 4'(len);
        Tbl_code = MAX_LEN'(code);
        tick();
        Tbl_we = 1'b0;
    endtask

    task automatic load_basic();
        tbl_write(0, 2, 'b00);
        tbl_write(1, 2, 'b01);
        tbl_write(2, 3, 'b100);
        tbl_write(3, 3, 'b101);
        tbl_write(4, 2, 'b11);
        for (int a = 5; a < SYM_N; a++) tbl_write(a, 0, 0);
    endtask

    task automatic start(input int cnt);
        Start_dec = 1'b1;
        Sym_count = CNT_W'(cnt);
        tick();
        Start_dec = 1'b0;
    endtask

    // Drives pattern[n-1] first with Bit_valid held high between bits.
    task automatic feed(input logic [15:0] pattern, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            logic acc;
            int   t;
            acc = 1'b0;
            t   = 0;
            Bit_valid = 1'b1;
            Bit_in    = pattern[i];
            while (!acc && t < 200) begin
                @(negedge Clk_in);
                if (Bit_ready) acc = 1'b1;
                @(posedge Clk_in);
                #1;
                t++;
            end
            check("bit_accepted", 32'(acc), 32'd1);
        end
        Bit_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (Busy && t < 400) begin
            tick();
            t++;
        end
        check("busy_falls", 32'(Busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        tick();
        Rst = 1'b0;
        check("rst_bit_ready", 32'(Bit_ready), 32'd0);
        check("rst_sym_valid", 32'(Sym_valid), 32'd0);
        check("rst_sym_out", 32'(Sym_out), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_fin", 32'(Fin), 32'd0);
        check("rst_err", 32'(Err), 32'd0);

        // Basic decode: 101 00 11 -> 3, 0, 4
        load_basic();
        Sym_ready = 1'b1;
        fin_cnt = 0;
        exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(4);
        start(3);
        check("busy_after_start", 32'(Busy), 32'd1);
        feed(16'b1010011, 7);
        wait_idle();
        check("basic_fin_count", 32'(fin_cnt), 32'd1);
        check("basic_err", 32'(Err), 32'd0);
        check("basic_q_empty", 32'(exp_q.size()), 32'd0);
`ifdef HUFF_DEC_STATS_EN
        check("bits_used", 32'(Bits_used), 32'd7);
`endif

        // Backpressure on the first symbol
        Sym_ready = 1'b0;
        fin_cnt = 0;
        exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(4);
        start(3);
        fork
            feed(16'b1010011, 7);
            begin
                int t;
                t = 0;
                @(negedge Clk_in);
                while (!Sym_valid && t < 100) begin
                    @(negedge Clk_in);
                    t++;
                end
                check("bp_valid_seen", 32'(Sym_valid), 32'd1);
                for (int k = 0; k < 5; k++) begin
                    check("bp_sym_hold", 32'(Sym_out), 32'd3);
                    check("bp_valid_hold", 32'(Sym_valid), 32'd1);
                    check("bp_bit_ready", 32'(Bit_ready), 32'd0);
                    if (k < 4) @(negedge Clk_in);
                end
                @(posedge Clk_in);
                #1;
                Sym_ready = 1'b1;
            end
        join
        wait_idle();
        check("bp_fin_count", 32'(fin_cnt), 32'd1);
        check("bp_q_empty", 32'(exp_q.size()), 32'd0);

        // Invalid code: only sym0 = 0/1, stream of nine ones
        tbl_write(0, 1, 0);
        for (int a = 1; a < SYM_N; a++) tbl_write(a, 0, 0);
        fin_cnt = 0;
        start(2);
        feed(16'h01FF, 9);
        wait_idle();
        check("inv_err", 32'(Err), 32'd1);
        check("inv_no_fin", 32'(fin_cnt), 32'd0);

        // Zero-count start clears Err and pulses Fin one cycle later
        start(0);
        check("zero_fin", 32'(Fin), 32'd1);
        check("zero_err_clr", 32'(Err), 32'd0);
        check("zero_busy", 32'(Busy), 32'd0);
        tick();
        check("zero_fin_drop", 32'(Fin), 32'd0);

        // Strobes mid-decode are ignored
        load_basic();
        fin_cnt = 0;
        exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(4);
        start(3);
        fork
            feed(16'b1010011, 7);
            begin
                tick();
                Tbl_we    = 1'b1;
                Tbl_addr  = 4'd3;
                Tbl_len   = 4'd0;
                Tbl_code  = '0;
                Start_dec = 1'b1;
                Sym_count = CNT_W'(1);
                tick();
                Tbl_we    = 1'b0;
                Start_dec = 1'b0;
            end
        join
        wait_idle();
        check("ign_fin_count", 32'(fin_cnt), 32'd1);
        check("ign_q_empty", 32'(exp_q.size()), 32'd0);
        check("ign_err", 32'(Err), 32'd0);

        // Reset during SHIFT after one bit
        start(3);
        feed(16'b1, 1);
        tick();
        check("pre_rst_ready", 32'(Bit_ready), 32'd1);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check("mid_rst_bit_ready", 32'(Bit_ready), 32'd0);
        check("mid_rst_sym_valid", 32'(Sym_valid), 32'd0);
        check("mid_rst_sym_out", 32'(Sym_out), 32'd0);
        check("mid_rst_busy", 32'(Busy), 32'd0);
        check("mid_rst_fin", 32'(Fin), 32'd0);
        check("mid_rst_err", 32'(Err), 32'd0);

        // Table was wiped: any nine bits end in Err
        fin_cnt = 0;
        start(1);
        feed(16'b101001110, 9);
        wait_idle();
        check("post_rst_err", 32'(Err), 32'd1);
        check("post_rst_no_fin", 32'(fin_cnt), 32'd0);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/huffman_decoder.md
Name: huffman_decoder

Overview:
Serial Huffman decoder. It is the receive/decode counterpart of the Huffman tree and encoder path. A per-symbol code table (length plus code, 10 symbols) is loaded while the block is idle. The block then consumes an MSB-first bitstream one bit per handshake and emits decoded symbol indices over a valid/ready interface until a programmed symbol count has been produced.

Parameters:
SYM_N, 10, number of symbols / table entries (indices 0..SYM_N-1)
MAX_LEN, 9, maximum code length in bits (SYM_N-1 for a full Huffman tree)
CNT_W, 16, width of the symbol-count register

Ports:
Clk_in  input  1  clock, all logic on rising edge
Rst  input  1  synchronous active-high reset
Tbl_we  input  1  table write strobe, honoured only in IDLE
Tbl_addr  input  4  table entry index; writes with Tbl_addr >= SYM_N are ignored
Tbl_len  input  4  code length; 0 = entry unused; values > MAX_LEN stored as 0
Tbl_code  input  MAX_LEN  code value, right-aligned (LSB = last bit of the code)
Start_dec  input  1  start pulse, honoured only in IDLE
Sym_count  input  CNT_W  number of symbols to decode, latched on Start_dec
Bit_in  input  1  stream bit
Bit_valid  input  1  Bit_in is valid
Bit_ready  output  1  decoder accepts a bit this cycle
Sym_out  output  4  decoded symbol index
Sym_valid  output  1  Sym_out is valid
Sym_ready  input  1  downstream accepts Sym_out
Busy  output  1  high in any state other than IDLE
Fin  output  1  one-cycle pulse when the last symbol is handed off
Err  output  1  sticky invalid-code flag

Behaviour:
- Reset: state IDLE; all table lengths 0; acc, len and remaining cleared. Outputs: Bit_ready=0, Sym_valid=0, Sym_out=0, Busy=0, Fin=0, Err=0.
- IDLE:
  - Tbl_we writes entry Tbl_addr.
  - Start_dec with Sym_count=0: Fin pulses on the next cycle; state stays IDLE.
  - Start_dec with Sym_count>0: latch remaining=Sym_count, clear acc, len and Err; go to SHIFT.
- SHIFT:
  - Bit_ready=1.
  - On Bit_valid&&Bit_ready: acc <= {acc[MAX_LEN-2:0],Bit_in}, len <= len+1, go to MATCH.
- MATCH (1 cycle, Bit_ready=0):
  - Entry i hits when Tbl_len[i]==len and Tbl_code[i]==acc.
  - If several entries hit, the lowest index wins.
  - Hit: Sym_out <= i, go to EMIT.
  - Miss with len<MAX_LEN: return to SHIFT.
  - Miss with len==MAX_LEN: set Err, go to IDLE.
- EMIT:
  - Sym_valid=1; Sym_out is held stable until Sym_valid&&Sym_ready.
  - On handoff: remaining decrements; acc and len clear.
  - If remaining was 1: Fin pulses in the same cycle, go to IDLE.
  - Otherwise go to SHIFT.
- Latency: Sym_valid rises 2 cycles after the last bit of a code is accepted (MATCH, then registered EMIT entry). Maximum throughput is one bit per 2 cycles.
- Start_dec and Tbl_we are ignored outside IDLE.
- Bit_valid is ignored outside SHIFT.
- Rst asserted mid-decode aborts the decode and restores the reset state in the following cycle, including the table.
- Err stays high until the next honoured Start_dec or Rst.

Optional Feature:
HUFF_DEC_STATS_EN
- Defined: adds output Bits_used [CNT_W+3:0]. It clears on an honoured Start_dec, increments on every accepted bit, and holds its value after Fin or Err.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
- Table load and basic decode: table sym0=00/2, sym1=01/2, sym2=100/3, sym3=101/3, sym4=11/2, rest len 0; Sym_count=3; bits 1,0,1,0,0,1,1 with Bit_valid held high and Sym_ready=1 -> Sym_out 3,0,4; one Fin pulse at the last handoff; Busy falls; Err=0.
- Backpressure: same stream, Sym_ready low for 5 cycles during the first EMIT -> Sym_out=3 held stable with Sym_valid high; Bit_ready=0 throughout; outputs resume unchanged afterwards.
- Invalid code: table with only sym0=0/1; stream 1 repeated 9 times -> Err=1 after the 9th MATCH; state IDLE; no Sym_valid. A following Start_dec clears Err.
- Zero count and ignored strobes: Start_dec with Sym_count=0 -> Fin on the next cycle, Busy stays 0. Tbl_we and Start_dec issued mid-decode -> no effect on the table or the decode.
- Reset mid-operation: Rst during SHIFT after 1 bit -> next cycle all outputs are at reset values and table lengths are 0. A subsequent decode without reloading the table -> Err after 9 bits.
- With HUFF_DEC_STATS_EN: first scenario -> Bits_used=7 after Fin.
